// File: rtl/reparam_sampler_if.sv
// Handshake bundle for reparam_sampler: mu/sigma/eps in, z/idx/last out.
// slave = the sampler itself, master = the upstream/downstream environment.
interface reparam_sampler_if #(
  parameter int BITSIZE    = 20,
  parameter int LATENT_DIM = 4
);
  localparam int IDXW = (LATENT_DIM > 1) ? $clog2(LATENT_DIM) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [BITSIZE-1:0] mu;
  logic signed [BITSIZE-1:0] sigma;
  logic signed [BITSIZE-1:0] eps;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [BITSIZE-1:0] out_z;
  logic [IDXW-1:0]           out_idx;
  logic                      out_last;

  modport slave (
    input  in_valid, mu, sigma, eps, out_ready,
    output in_ready, out_valid, out_z, out_idx, out_last
  );

  modport master (
    output in_valid, mu, sigma, eps, out_ready,
    input  in_ready, out_valid, out_z, out_idx, out_last
  );
endinterface

// File: rtl/reparam_sampler.sv
// reparam_sampler: z = mu + sigma * eps, 3-stage valid/ready pipeline with a
// latent-index counter. Optional feature macro: SAMPLER_SATURATE_EN (clamp r
// and s to the signed BITSIZE range instead of wrapping).
module reparam_sampler #(
  parameter int BITSIZE    = 20,
  parameter int FRAC       = 15,
  parameter int LATENT_DIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  reparam_sampler_if.slave  bus
);
  localparam int IDXW = (LATENT_DIM > 1) ? $clog2(LATENT_DIM) : 1;
  localparam int PW   = 2 * BITSIZE;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC - 1);
`ifdef SAMPLER_SATURATE_EN
  localparam int RW = PW - FRAC;
  localparam logic signed [BITSIZE-1:0] MAXB = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic signed [BITSIZE-1:0] MINB = {1'b1, {(BITSIZE-1){1'b0}}};
`endif

  logic                      advance;
  logic                      v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [BITSIZE-1:0] mu1_q, mu1_d, sg1_q, sg1_d, ep1_q, ep1_d;
  logic signed [BITSIZE-1:0] mu2_q, mu2_d, r2_q, r2_d;
  logic signed [BITSIZE-1:0] z_q, z_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic                      last_q, last_d;
  logic signed [PW-1:0]      prod;
  logic signed [BITSIZE-1:0] r_red, s_red;
`ifdef SAMPLER_SATURATE_EN
  logic signed [RW-1:0]      r_wide;
  logic [RW-BITSIZE:0]       r_top;
  logic signed [BITSIZE:0]   s_wide;
`endif

  assign advance       = !v3_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v3_q;
  assign bus.out_z     = z_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;

  // Stage-2/3 arithmetic: rounded product and final sum.
  always_comb begin
    prod = PW'(sg1_q) * PW'(ep1_q);
`ifdef SAMPLER_SATURATE_EN
    r_wide = RW'((prod + HALF) >>> FRAC);
    r_top  = r_wide[RW-1:BITSIZE-1];
    r_red  = r_wide[BITSIZE-1:0];
    if (!(&r_top) && (|r_top)) r_red = r_wide[RW-1] ? MINB : MAXB;
    s_wide = {mu2_q[BITSIZE-1], mu2_q} + {r2_q[BITSIZE-1], r2_q};
    s_red  = s_wide[BITSIZE-1:0];
    if (s_wide[BITSIZE] != s_wide[BITSIZE-1]) s_red = s_wide[BITSIZE] ? MINB : MAXB;
`else
    // wrapping mode: truncating r first and adding at BITSIZE equals the
    // BITSIZE+1-bit sum reduced to BITSIZE (modular arithmetic)
    r_red = BITSIZE'((prod + HALF) >>> FRAC);
    s_red = mu2_q + r2_q;
`endif
  end

  // Next-state: whole pipeline shifts on advance, index counts output transfers.
  always_comb begin
    v1_d = v1_q; mu1_d = mu1_q; sg1_d = sg1_q; ep1_d = ep1_q;
    v2_d = v2_q; mu2_d = mu2_q; r2_d = r2_q;
    v3_d = v3_q; z_d = z_q;
    idx_d = idx_q;
    if (advance) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        mu1_d = bus.mu; sg1_d = bus.sigma; ep1_d = bus.eps;
      end
      v2_d = v1_q;
      if (v1_q) begin
        mu2_d = mu1_q; r2_d = r_red;
      end
      v3_d = v2_q;
      if (v2_q) z_d = s_red;
    end
    if (v3_q && bus.out_ready)
      idx_d = (idx_q == IDXW'(LATENT_DIM - 1)) ? '0 : idx_q + 1'b1;
    last_d = v3_d && (idx_d == IDXW'(LATENT_DIM - 1));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      mu1_q <= '0; sg1_q <= '0; ep1_q <= '0;
      mu2_q <= '0; r2_q <= '0;
      z_q <= '0; idx_q <= '0; last_q <= 1'b0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      mu1_q <= mu1_d; sg1_q <= sg1_d; ep1_q <= ep1_d;
      mu2_q <= mu2_d; r2_q <= r2_d;
      z_q <= z_d; idx_q <= idx_d; last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_reparam_sampler.sv
// Scoreboard bench for reparam_sampler: inputs observed at transfer push the
// reference result; an independent monitor checks each presented output.
module tb_reparam_sampler;
  localparam int B  = 20;
  localparam int F  = 15;
  localparam int LD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reparam_sampler_if #(.BITSIZE(B), .LATENT_DIM(LD)) bus ();
  reparam_sampler #(.BITSIZE(B), .FRAC(F), .LATENT_DIM(LD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic signed [B-1:0] z;
    int unsigned         idx;
  } exp_t;

  exp_t        q[$];
  int unsigned exp_idx = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          mode = 0;   // out_ready: 0 always high, 1 random, 2 held low

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: real-valued rule mu + round(sigma*eps / 2^F) at integer precision.
  function automatic logic signed [B-1:0] model(input longint mu, input longint sg,
                                                input longint ep);
    longint lo = -(longint'(1) << (B - 1));
    longint hi = (longint'(1) << (B - 1)) - 1;
    longint r  = (sg * ep + (longint'(1) << (F - 1))) >>> F;
    longint s;
`ifdef SAMPLER_SATURATE_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    s = mu + r;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    s = mu + r;
`endif
    return s[B-1:0];
  endfunction

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      exp_idx = 0;
    end else begin
      chk("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q[0];
          chk("out_z", longint'(bus.out_z), longint'(e.z));
          chk("out_idx", longint'(bus.out_idx), longint'(e.idx));
          chk("out_last", longint'(bus.out_last), longint'(e.idx == LD - 1));
          if (bus.out_ready) void'(q.pop_front());
        end
      end else chk("last_idle", longint'(bus.out_last), 0);
      if (bus.in_valid && bus.in_ready) begin
        e.z   = model(longint'(bus.mu), longint'(bus.sigma), longint'(bus.eps));
        e.idx = exp_idx;
        q.push_back(e);
        exp_idx = (exp_idx + 1) % LD;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send(input logic signed [B-1:0] m, input logic signed [B-1:0] s,
                      input logic signed [B-1:0] e);
    int n = 0;
    bus.mu = m; bus.sigma = s; bus.eps = e; bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 100);
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic direct(input logic signed [B-1:0] m, input logic signed [B-1:0] s,
                        input logic signed [B-1:0] e, input longint expz);
    int lat = 1;
    send(m, s, e);
    while (!bus.out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, 3);
    chk("direct_z", longint'(bus.out_z), expz);
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.mu = '0; bus.sigma = '0; bus.eps = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", longint'(bus.out_valid), 0);
    chk("rst_z", longint'(bus.out_z), 0);
    chk("rst_idx", longint'(bus.out_idx), 0);
    chk("rst_last", longint'(bus.out_last), 0);
    @(posedge clk); #1;

    direct(20'sd1000, 20'sd32768, 20'sd32768, 33768);
    direct(20'sd0, 20'sd65536, 20'sd3640, 7280);
    direct(-20'sd500, 20'sd65536, 20'sd0, -500);
`ifdef SAMPLER_SATURATE_EN
    direct(20'sd500000, 20'sd65536, 20'sd32768, 524287);
`else
    direct(20'sd500000, 20'sd65536, 20'sd32768, -483040);
`endif
    direct(20'sd1234, 20'sd32768, 20'sd32768, 1234 + 32768);

    // stall mid-stream
    fork
      for (int i = 0; i < 8; i++)
        send(B'($urandom_range(0, 4000)), B'($urandom_range(0, 70000)),
             B'($urandom_range(0, 40000)));
      begin
        repeat (4) @(negedge clk);
        mode = 2;
        repeat (5) @(negedge clk);
        mode = 0;
      end
    join
    idle(6);

    // reset with two samples in flight
    send(20'sd11, 20'sd32768, 20'sd32768);
    send(20'sd22, 20'sd32768, 20'sd32768);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_z", longint'(bus.out_z), 0);
    chk("mid_rst_idx", longint'(bus.out_idx), 0);
    @(posedge clk); #1;

    // six samples: idx 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) send(B'(i * 100), 20'sd32768, B'(i * 7));
    idle(6);

    // randomized traffic with random backpressure and gaps
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(B'($urandom), B'($urandom), B'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    mode = 0;
    for (int n = 0; n < 100 && q.size() != 0; n++) idle(1);
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
